// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver):
// FSM state encoding, default frame geometry and the idle line level.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

  localparam logic LINE_IDLE = 1'b1;

  // Counter width that still yields a 1-bit register when n <= 2.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: counts clocks while a frame runs and pulses tick on the
// last clock of every bit period.
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int                CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // With CLKS_PER_BIT=1 the counter sits at 0 == LAST, so tick follows run.
  assign tick = run && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: accepts a word over valid/ready and sends a start
// bit, DATA_W data bits LSB-first and a stop bit, each CLKS_PER_BIT clocks.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  localparam int                IDX_W    = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [IDX_W-1:0]  idx;
  logic              tick;

  assign shreg_next = shreg >> 1;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .run (busy),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      // NOTE: the shift register is reset too; it is small and this keeps the
      // whole datapath defined after reset for the receiver-side checks.
      shreg     <= '0;
      idx       <= '0;
      tx        <= LINE_IDLE;
      busy      <= 1'b0;
      din_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (din_valid && din_ready) begin
            shreg     <= din;
            state     <= S_START;
            tx        <= ~LINE_IDLE;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            state <= S_DATA;
            idx   <= '0;
            tx    <= shreg[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
              state <= S_STOP;
              tx    <= LINE_IDLE;
            end else begin
              shreg <= shreg_next;
              idx   <= idx + IDX_W'(1);
              tx    <= shreg_next[0];
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            din_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at CLKS_PER_BIT=4, one at 1,
// with a line-level reference and a receiver model fed from a word scoreboard.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [1:0]   valid;
  wire  [1:0]   ready;
  wire  [1:0]   tx;
  wire  [1:0]   busy;
  wire  [1:0]   done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(valid[0]),
    .din_ready(ready[0]),
    .tx       (tx[0]),
    .busy     (busy[0]),
    .done     (done[0])
  );

  serial_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(valid[1]),
    .din_ready(ready[1]),
    .tx       (tx[1]),
    .busy     (busy[1]),
    .done     (done[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  task automatic check_idle(input int sel, input string tag);
    check($sformatf("%s_tx%0d", tag, sel), tx[sel], LINE_IDLE);
    check($sformatf("%s_busy%0d", tag, sel), busy[sel], 0);
    check($sformatf("%s_done%0d", tag, sel), done[sel], 0);
    check($sformatf("%s_ready%0d", tag, sel), ready[sel], 1);
  endtask

  // Sends one word and checks every cycle of the frame. Ends in the done cycle.
  // after_din is applied right after accept; hold keeps din_valid high through
  // the frame; pulse_cyc (>=0) pulses din_valid with 0x3C at that frame cycle.
  task automatic run_frame(input int sel, input logic [W-1:0] data,
                           input logic [W-1:0] after_din, input bit hold,
                           input int pulse_cyc);
    int           c_per;
    int           cyc;
    logic         exp_bit;
    logic [W-1:0] rx;
    c_per = cpb_of(sel);
    check($sformatf("pre_ready%0d", sel), ready[sel], 1);
    din        = data;
    valid[sel] = 1'b1;
    exp_q.push_back(data);
    step();
    din        = after_din;
    valid[sel] = hold;
    rx         = '0;
    cyc        = 0;
    for (int k = 0; k < W + 2; k++) begin
      if (k == 0)          exp_bit = 1'b0;
      else if (k == W + 1) exp_bit = LINE_IDLE;
      else                 exp_bit = data[k-1];
      for (int c = 0; c < c_per; c++) begin
        check($sformatf("tx s%0d k%0d c%0d", sel, k, c), tx[sel], exp_bit);
        check($sformatf("busy s%0d k%0d c%0d", sel, k, c), busy[sel], 1);
        check($sformatf("ready s%0d k%0d c%0d", sel, k, c), ready[sel], 0);
        check($sformatf("done s%0d k%0d c%0d", sel, k, c), done[sel], 0);
        if (k >= 1 && k <= W && c == c_per / 2) rx[k-1] = tx[sel];
        if (cyc == pulse_cyc) begin
          din        = 8'h3C;
          valid[sel] = 1'b1;
        end else if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) begin
          valid[sel] = 1'b0;
        end
        cyc++;
        step();
      end
    end
    check($sformatf("end_done%0d", sel), done[sel], 1);
    check($sformatf("end_ready%0d", sel), ready[sel], 1);
    check($sformatf("end_busy%0d", sel), busy[sel], 0);
    check($sformatf("end_tx%0d", sel), tx[sel], LINE_IDLE);
    if (exp_q.size() > 0) check($sformatf("rx_word%0d", sel), rx, exp_q.pop_front());
    else check($sformatf("rx_word_unexpected%0d", sel), rx, 'x);
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    din   = '0;

    // Reset held for two cycles, then ten quiet idle cycles.
    step();
    step();
    check_idle(0, "reset");
    check_idle(1, "reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle(0, "post_reset");
      check_idle(1, "post_reset");
    end

    // Single frame 0xA5; din changes after accept.
    run_frame(0, 8'hA5, 8'h5A, 1'b0, -1);
    step();
    check("done_one_cycle_a5", done[0], 0);
    check("idle_tx_a5", tx[0], LINE_IDLE);

    // Back-to-back: din_valid held across done, second word waiting.
    run_frame(0, 8'h00, 8'hFF, 1'b1, -1);
    run_frame(0, 8'hFF, 8'h00, 1'b0, -1);
    step();
    check("done_one_cycle_ff", done[0], 0);

    // Busy ignore: 0x3C pulse in the middle of 0x81.
    run_frame(0, 8'h81, 8'h81, 1'b0, 13);
    step();
    check("done_one_cycle_81", done[0], 0);
    check("no_extra_frame_81", busy[0], 0);
    step();
    check("no_extra_frame_81b", busy[0], 0);

    // Reset during data bit 3 of 0x55, with an accept request in the same cycle.
    check("pre_ready_55", ready[0], 1);
    din      = 8'h55;
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("mid_55_tx_bit3", tx[0], 0);
    check("mid_55_busy", busy[0], 1);
    rst      = 1'b1;
    valid[0] = 1'b1;
    step();
    rst      = 1'b0;
    valid[0] = 1'b0;
    check_idle(0, "mid_reset");
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle(0, "after_mid_reset");
    end

    run_frame(0, 8'h0F, 8'hF0, 1'b0, -1);
    step();
    check("done_one_cycle_0f", done[0], 0);

    // One clock per bit.
    run_frame(1, 8'h01, 8'h00, 1'b0, -1);
    step();
    check("done_one_cycle_cpb1", done[1], 0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
